// File: rtl/mvm_seq_ctrl_pkg.sv
// Shared types for the MVM sequencer: controller states and
// the MAC row-period helper.
package mvm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_X,
        ST_COMP,
        ST_OUT_PRIME,
        ST_OUT
    } state_t;

    // K issue/drain cycles plus the write cycle shared with the next row.
    function automatic int row_period(input int k);
        return k + 1;
    endfunction

endpackage

// File: rtl/mvm_seq_ctrl_if.sv
// Load and result-stream handshakes between the mvm wrapper
// and the sequencer.
interface mvm_seq_ctrl_if;

    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );

endinterface

// File: rtl/mvm_seq_ctrl_idx_counter.sv
// Wrapping index counter with clear priority and a terminal flag.
// The terminal value is a port so one counter can serve A and x loads.
module mvm_idx_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         last
);

    assign last = (cnt == term);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mvm_seq_ctrl.sv
// Handshaked sequencer for the MVM datapath: loads A and x,
// runs the MAC schedule, then streams y under backpressure.
module mvm_seq_ctrl
    import mvm_ctrl_pkg::*;
#(
    parameter int K     = 32,
    parameter int LOGK  = $clog2(K),
    parameter int LOGKK = $clog2(K*K)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             loadMatrix,
    input  logic             loadVector,
    mvm_seq_ctrl_if.slave    hs,
    output logic [LOGKK-1:0] addr_a,
    output logic [LOGK-1:0]  addr_x,
    output logic [LOGK-1:0]  addr_y,
    output logic             wr_en_a,
    output logic             wr_en_x,
    output logic             wr_en_y,
    output logic             clear_acc,
    output logic             busy,
    output logic             done
);

    localparam logic [LOGKK-1:0] A_TERM = LOGKK'(K*K - 1);
    localparam logic [LOGKK-1:0] X_TERM = LOGKK'(K - 1);
    localparam logic [LOGK:0]    J_TERM = (LOGK+1)'(row_period(K) - 1);
    localparam logic [LOGK-1:0]  I_TERM = LOGK'(K - 1);

    state_t state;
    state_t nxt;

    logic             idle;
    logic             comp;
    logic             ld_st;
    logic             in_hs;
    logic             out_hs;
    logic [LOGKK-1:0] ld_cnt;
    logic [LOGKK-1:0] ld_term;
    logic             ld_last;
    logic [LOGK:0]    j_cnt;
    logic             j_last;
    logic [LOGK-1:0]  i_cnt;
    logic             i_last;
    logic [LOGK-1:0]  o_cnt;
    logic             o_last;
    logic             wr_pend;
    logic             tail;

    assign idle    = (state == ST_IDLE);
    assign comp    = (state == ST_COMP);
    assign ld_st   = (state == ST_LOAD_A) || (state == ST_LOAD_X);
    assign in_hs   = ld_st & hs.in_valid;
    assign out_hs  = (state == ST_OUT) & hs.out_ready;
    assign ld_term = (state == ST_LOAD_A) ? A_TERM : X_TERM;
    assign busy    = ~idle;

    mvm_idx_counter #(.W(LOGKK)) u_ld (
        .clk   (clk),
        .reset (reset),
        .clr   (idle),
        .inc   (in_hs),
        .term  (ld_term),
        .cnt   (ld_cnt),
        .last  (ld_last)
    );

    mvm_idx_counter #(.W(LOGK+1)) u_j (
        .clk   (clk),
        .reset (reset),
        .clr   (idle),
        .inc   (comp & ~tail),
        .term  (J_TERM),
        .cnt   (j_cnt),
        .last  (j_last)
    );

    mvm_idx_counter #(.W(LOGK)) u_i (
        .clk   (clk),
        .reset (reset),
        .clr   (idle),
        .inc   (comp & j_last),
        .term  (I_TERM),
        .cnt   (i_cnt),
        .last  (i_last)
    );

    mvm_idx_counter #(.W(LOGK)) u_o (
        .clk   (clk),
        .reset (reset),
        .clr   (idle),
        .inc   (out_hs),
        .term  (I_TERM),
        .cnt   (o_cnt),
        .last  (o_last)
    );

    // wr_pend marks the cycle after a drain; tail is the lone final write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            wr_pend <= 1'b0;
            tail    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= nxt;
            wr_pend <= comp & j_last;
            tail    <= comp & j_last & i_last;
            done    <= out_hs & o_last;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (start)           nxt = ST_COMP;
                else if (loadMatrix) nxt = ST_LOAD_A;
                else if (loadVector) nxt = ST_LOAD_X;
            end
            ST_LOAD_A,
            ST_LOAD_X: begin
                if (in_hs && ld_last) nxt = ST_IDLE;
            end
            ST_COMP: begin
                if (tail) nxt = ST_OUT_PRIME;
            end
            ST_OUT_PRIME: nxt = ST_OUT;
            ST_OUT: begin
                if (out_hs && o_last) nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hs.in_ready  = 1'b0;
        hs.out_valid = 1'b0;
        addr_a       = '0;
        addr_x       = '0;
        addr_y       = '0;
        wr_en_a      = 1'b0;
        wr_en_x      = 1'b0;
        wr_en_y      = 1'b0;
        clear_acc    = 1'b0;
        unique case (state)
            ST_LOAD_A: begin
                hs.in_ready = 1'b1;
                wr_en_a     = hs.in_valid;
                addr_a      = ld_cnt;
            end
            ST_LOAD_X: begin
                hs.in_ready = 1'b1;
                wr_en_x     = hs.in_valid;
                addr_x      = ld_cnt[LOGK-1:0];
            end
            ST_COMP: begin
                if (!tail) begin
                    addr_a    = {i_cnt, j_cnt[LOGK-1:0]};
                    addr_x    = j_cnt[LOGK-1:0];
                    clear_acc = (j_cnt == '0);
                end
                // i has already advanced, so the finished row is i-1 (mod K).
                if (wr_pend) begin
                    wr_en_y = 1'b1;
                    addr_y  = i_cnt - 1'b1;
                end
            end
            ST_OUT: begin
                hs.out_valid = 1'b1;
                addr_y       = hs.out_ready ? o_cnt + 1'b1 : o_cnt;
            end
            default: ;
        endcase
    end

endmodule
